// File: rtl/matmul_pkg.sv
// Shared parameters, address map, CONTROL field layout and bus types for the
// matrix-multiply APB front-end.
package matmul_pkg;
  localparam int DATA_WIDTH  = 8;
  localparam int BUS_WIDTH   = 32;
  localparam int ADDR_WIDTH  = 16;
  localparam int MAX_DIM     = BUS_WIDTH / DATA_WIDTH;
  localparam int SP_NTARGETS = 4;

  localparam logic [31:0] CTRL_ADDR  = 32'h000;
  localparam logic [31:0] FLAGS_ADDR = 32'h004;
  localparam logic [31:0] A_BASE     = 32'h010;
  localparam logic [31:0] B_BASE     = 32'h030;
  localparam logic [31:0] SP_BASE    = 32'h100;

  localparam int CTRL_START     = 0;
  localparam int CTRL_MODE_BIAS = 1;
  localparam int CTRL_WR_TGT    = 2;
  localparam int CTRL_RD_TGT    = 4;
  localparam int CTRL_N         = 8;
  localparam int CTRL_K         = 10;
  localparam int CTRL_M         = 12;
  localparam int FLAGS_BUSY     = 31;

  // Storable CONTROL bits; START is a pulse and never held.
  localparam logic [15:0] CTRL_MASK = 16'((1 << CTRL_MODE_BIAS) | (3 << CTRL_WR_TGT) |
                                          (3 << CTRL_RD_TGT) | (3 << CTRL_N) |
                                          (3 << CTRL_K) | (3 << CTRL_M));

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, SP_WAIT} bus_state_t;
  typedef enum logic [2:0] {R_NONE, R_CTRL, R_FLAGS, R_A, R_B, R_SP} region_t;
endpackage

// File: rtl/matmul_addr_decode.sv
// Combinational region select, row/element index extraction and error flag.
module matmul_addr_decode import matmul_pkg::*; #(
  parameter int ADDR_WIDTH = matmul_pkg::ADDR_WIDTH,
  parameter int MAX_DIM    = matmul_pkg::MAX_DIM,
  parameter int SP_DEPTH   = matmul_pkg::SP_NTARGETS * MAX_DIM * MAX_DIM,
  parameter int ROW_W      = $clog2(MAX_DIM),
  parameter int SP_AW      = $clog2(SP_DEPTH)
) (
  input  logic [ADDR_WIDTH-3:0] waddr,
  input  logic                  pwrite,
  input  logic                  busy,
  output region_t               region,
  output logic [ROW_W-1:0]      row,
  output logic [SP_AW-1:0]      sp_idx,
  output logic                  err
);
  logic [31:0] off, d_a, d_b, d_sp;

  always_comb begin
    off    = {{(34-ADDR_WIDTH){1'b0}}, waddr};
    d_a    = off - (A_BASE >> 2);
    d_b    = off - (B_BASE >> 2);
    d_sp   = off - (SP_BASE >> 2);
    region = R_NONE;
    row    = '0;
    sp_idx = '0;
    err    = 1'b1;
    if (off == (CTRL_ADDR >> 2)) begin
      region = R_CTRL;
      err    = pwrite && busy;
    end else if (off == (FLAGS_ADDR >> 2)) begin
      region = R_FLAGS;
      err    = pwrite;
    end else if (off >= (A_BASE >> 2) && d_a < 32'(MAX_DIM)) begin
      region = R_A;
      row    = d_a[ROW_W-1:0];
      err    = pwrite && busy;
    end else if (off >= (B_BASE >> 2) && d_b < 32'(MAX_DIM)) begin
      region = R_B;
      row    = d_b[ROW_W-1:0];
      err    = pwrite && busy;
    end else if (off >= (SP_BASE >> 2) && d_sp < 32'(SP_DEPTH)) begin
      region = R_SP;
      sp_idx = d_sp[SP_AW-1:0];
      err    = pwrite;
    end
  end
endmodule

// File: rtl/matmul_apb_slave.sv
// APB slave front-end: CONTROL/FLAGS registers, operand row buffers, scratchpad
// reads with one wait state, and the engine start/busy handshake.
module matmul_apb_slave import matmul_pkg::*; #(
  parameter int DATA_WIDTH  = matmul_pkg::DATA_WIDTH,
  parameter int BUS_WIDTH   = matmul_pkg::BUS_WIDTH,
  parameter int ADDR_WIDTH  = matmul_pkg::ADDR_WIDTH,
  parameter int MAX_DIM     = BUS_WIDTH / DATA_WIDTH,
  parameter int SP_NTARGETS = matmul_pkg::SP_NTARGETS
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         psel_i,
  input  logic                         penable_i,
  input  logic                         pwrite_i,
  input  logic [ADDR_WIDTH-1:0]        paddr_i,
  input  logic [BUS_WIDTH-1:0]         pwdata_i,
  input  logic [MAX_DIM-1:0]           pstrb_i,
  output logic                         pready_o,
  output logic [BUS_WIDTH-1:0]         prdata_o,
  output logic                         pslverr_o,
  output logic                         start_o,
  output logic [15:0]                  ctrl_o,
  output logic [MAX_DIM*BUS_WIDTH-1:0] a_rows_o,
  output logic [MAX_DIM*BUS_WIDTH-1:0] b_rows_o,
  input  logic                         done_i,
  input  logic [MAX_DIM*MAX_DIM-1:0]   flags_i,
  output logic                         sp_rd_en_o,
  output logic [$clog2(SP_NTARGETS*MAX_DIM*MAX_DIM)-1:0] sp_rd_addr_o,
  input  logic [BUS_WIDTH-1:0]         sp_rd_data_i
);
  localparam int SP_DEPTH = SP_NTARGETS * MAX_DIM * MAX_DIM;
  localparam int SP_AW    = $clog2(SP_DEPTH);
  localparam int ROW_W    = $clog2(MAX_DIM);
  localparam int NFLAGS   = MAX_DIM * MAX_DIM;

  bus_state_t                        state_q, state_d;
  logic                              busy_q, start_q;
  logic [15:0]                       ctrl_q;
  logic [NFLAGS-1:0]                 flags_q;
  logic [BUS_WIDTH-1:0]              sp_data_q, rd_mux;
  logic [MAX_DIM-1:0][BUS_WIDTH-1:0] a_rows, b_rows;
  region_t                           region;
  logic [ROW_W-1:0]                  row;
  logic [SP_AW-1:0]                  sp_idx;
  logic                              dec_err, sp_rd_ok, wr_ok, start_set;
  logic                              unused_addr_lsb;

  assign unused_addr_lsb = ^paddr_i[1:0];

  matmul_addr_decode #(
    .ADDR_WIDTH(ADDR_WIDTH), .MAX_DIM(MAX_DIM), .SP_DEPTH(SP_DEPTH),
    .ROW_W(ROW_W), .SP_AW(SP_AW)
  ) u_dec (
    .waddr (paddr_i[ADDR_WIDTH-1:2]),
    .pwrite(pwrite_i),
    .busy  (busy_q),
    .region(region),
    .row   (row),
    .sp_idx(sp_idx),
    .err   (dec_err)
  );

  function automatic logic [BUS_WIDTH-1:0] merge(input logic [BUS_WIDTH-1:0] old,
                                                 input logic [BUS_WIDTH-1:0] wd,
                                                 input logic [MAX_DIM-1:0]   strb);
    merge = old;
    for (int b = 0; b < MAX_DIM; b++)
      if (strb[b]) merge[b*DATA_WIDTH +: DATA_WIDTH] = wd[b*DATA_WIDTH +: DATA_WIDTH];
  endfunction

  assign sp_rd_ok  = psel_i && !pwrite_i && (region == R_SP) && !dec_err;
  assign wr_ok     = (state_q == ACCESS) && psel_i && pwrite_i && !dec_err;
  assign start_set = wr_ok && (region == R_CTRL) && pstrb_i[0] && pwdata_i[CTRL_START];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      start_q   <= 1'b0;
      ctrl_q    <= '0;
      flags_q   <= '0;
      sp_data_q <= '0;
      a_rows    <= '0;
      b_rows    <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start_set;
      // A start landing with done keeps the engine busy.
      if (start_set)   busy_q <= 1'b1;
      else if (done_i) busy_q <= 1'b0;
      if (done_i) flags_q <= flags_i;
      if (wr_ok && region == R_CTRL)
        for (int b = 0; b < 2; b++)
          if (pstrb_i[b]) ctrl_q[b*8 +: 8] <= pwdata_i[b*8 +: 8] & CTRL_MASK[b*8 +: 8];
      if (wr_ok && region == R_A) a_rows[row] <= merge(a_rows[row], pwdata_i, pstrb_i);
      if (wr_ok && region == R_B) b_rows[row] <= merge(b_rows[row], pwdata_i, pstrb_i);
      if (state_q == ACCESS && sp_rd_ok) sp_data_q <= sp_rd_data_i;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (region)
      R_CTRL:  rd_mux[15:0] = ctrl_q;
      R_FLAGS: begin
        rd_mux[NFLAGS-1:0] = flags_q;
        rd_mux[FLAGS_BUSY] = busy_q;
      end
      R_A:     rd_mux = a_rows[row];
      R_B:     rd_mux = b_rows[row];
      default: ;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    pready_o     = 1'b0;
    prdata_o     = '0;
    pslverr_o    = 1'b0;
    sp_rd_en_o   = 1'b0;
    sp_rd_addr_o = '0;
    case (state_q)
      IDLE: if (psel_i && !penable_i) state_d = SETUP;
      SETUP: begin
        if (!psel_i) state_d = IDLE;
        else begin
          state_d = ACCESS;
          if (sp_rd_ok) begin
            sp_rd_en_o   = 1'b1;
            sp_rd_addr_o = sp_idx;
          end
        end
      end
      ACCESS: begin
        if (!psel_i) state_d = IDLE;
        else if (sp_rd_ok) state_d = SP_WAIT;
        else begin
          pready_o  = 1'b1;
          pslverr_o = dec_err;
          prdata_o  = (dec_err || pwrite_i) ? '0 : rd_mux;
          state_d   = IDLE;
        end
      end
      SP_WAIT: begin
        if (psel_i) begin
          pready_o = 1'b1;
          prdata_o = sp_data_q;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign start_o  = start_q;
  assign ctrl_o   = ctrl_q;
  assign a_rows_o = a_rows;
  assign b_rows_o = b_rows;
endmodule

// File: tb/tb_matmul_apb_slave.sv
// Directed bench for matmul_apb_slave: stimulus pushes expected APB responses,
// a monitor pops and compares them whenever pready_o is seen.
module tb_matmul_apb_slave;
  logic         clk = 1'b0, rst_ni = 1'b0;
  logic         psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [15:0]  paddr = '0;
  logic [31:0]  pwdata = '0;
  logic [3:0]   pstrb = '0;
  logic         pready, pslverr, start, done = 1'b0, sp_rd_en;
  logic [31:0]  prdata, sp_rd_data = '0;
  logic [15:0]  ctrl, flags = '0;
  logic [127:0] a_rows, b_rows;
  logic [5:0]   sp_rd_addr, last_sp_addr = '0;

  int checks = 0, errors = 0;

  typedef struct {
    string       name;
    logic [31:0] rd;
    logic        err;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  matmul_apb_slave dut (
    .clk_i(clk), .rst_ni(rst_ni), .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
    .paddr_i(paddr), .pwdata_i(pwdata), .pstrb_i(pstrb), .pready_o(pready),
    .prdata_o(prdata), .pslverr_o(pslverr), .start_o(start), .ctrl_o(ctrl),
    .a_rows_o(a_rows), .b_rows_o(b_rows), .done_i(done), .flags_i(flags),
    .sp_rd_en_o(sp_rd_en), .sp_rd_addr_o(sp_rd_addr), .sp_rd_data_i(sp_rd_data)
  );

  // Scratchpad model: element e returns 0xAA + e one cycle after the request.
  always @(posedge clk) if (sp_rd_en) sp_rd_data <= 32'hAA + {26'b0, sp_rd_addr};
  always @(negedge clk) if (sp_rd_en) last_sp_addr = sp_rd_addr;

  always @(negedge clk) begin
    if (rst_ni && pready) begin
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pready: prdata=%h pslverr=%b with nothing expected", prdata, pslverr);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        if (prdata !== e.rd || pslverr !== e.err) begin
          errors++;
          $display("FAIL %s: got prdata=%h pslverr=%b, expected prdata=%h pslverr=%b",
                   e.name, prdata, pslverr, e.rd, e.err);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // exp_lat: cycles from penable assertion to the pready cycle (inclusive).
  task automatic apb(input string name, input logic wr, input logic [15:0] addr,
                     input logic [31:0] data, input logic [3:0] strb,
                     input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
    int n = 0;
    sb.push_back('{name, exp_rd, exp_err});
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
    @(posedge clk); #1;
    penable = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!pready && n < 20);
    if (!pready) begin
      errors++;
      void'(sb.pop_back());
      $display("FAIL %s_timeout: no pready after %0d cycles", name, n);
    end else check({name, "_latency"}, n, exp_lat);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  initial begin
    #3;
    check("rst_pready", {31'b0, pready}, 0);
    check("rst_prdata", prdata, 0);
    check("rst_pslverr", {31'b0, pslverr}, 0);
    check("rst_start", {31'b0, start}, 0);
    check("rst_sp_rd_en", {31'b0, sp_rd_en}, 0);
    check("rst_ctrl", {16'b0, ctrl}, 0);
    check("rst_a_row0", a_rows[31:0], 0);
    @(posedge clk); #1 rst_ni = 1'b1;

    apb("wr_a0", 1, 16'h010, 32'h04030201, 4'hF, 32'h0, 0, 2);
    apb("rd_a0", 0, 16'h010, 32'h0, 4'h0, 32'h04030201, 0, 2);
    apb("wr_a0_strb", 1, 16'h010, 32'hFFFFFFFF, 4'h2, 32'h0, 0, 2);
    apb("rd_a0_strb", 0, 16'h010, 32'h0, 4'h0, 32'h0403FF01, 0, 2);
    check("a_rows_o_row0", a_rows[31:0], 32'h0403FF01);

    apb("wr_ctrl", 1, 16'h000, 32'h00003A02, 4'h3, 32'h0, 0, 2);
    check("ctrl_o", {16'b0, ctrl}, 32'h3A02);
    apb("rd_ctrl", 0, 16'h000, 32'h0, 4'h0, 32'h00003A02, 0, 2);

    apb("wr_start", 1, 16'h000, 32'h00000001, 4'h1, 32'h0, 0, 2);
    check("start_pulse", {31'b0, start}, 1);
    @(posedge clk); #1;
    check("start_one_cycle", {31'b0, start}, 0);
    check("ctrl_after_start", {16'b0, ctrl}, 32'h3A00);
    apb("rd_flags_busy", 0, 16'h004, 32'h0, 4'h0, 32'h80000000, 0, 2);
    apb("wr_b0_busy", 1, 16'h030, 32'hDEADBEEF, 4'hF, 32'h0, 1, 2);
    apb("rd_b0_busy", 0, 16'h030, 32'h0, 4'h0, 32'h0, 0, 2);
    apb("wr_start_busy", 1, 16'h000, 32'h00000001, 4'h1, 32'h0, 1, 2);
    check("no_start_when_busy", {31'b0, start}, 0);

    @(posedge clk); #1 done = 1'b1; flags = 16'h0005;
    @(posedge clk); #1 done = 1'b0; flags = 16'h0000;
    apb("rd_flags_done", 0, 16'h004, 32'h0, 4'h0, 32'h00000005, 0, 2);
    apb("wr_a1_idle", 1, 16'h014, 32'h11223344, 4'hF, 32'h0, 0, 2);
    apb("rd_a1", 0, 16'h014, 32'h0, 4'h0, 32'h11223344, 0, 2);

    apb("rd_sp1", 0, 16'h104, 32'h0, 4'h0, 32'h000000AB, 0, 3);
    check("sp_rd_addr", {26'b0, last_sp_addr}, 1);

    apb("rd_unmapped", 0, 16'h200, 32'h0, 4'h0, 32'h0, 1, 2);
    apb("wr_flags_ro", 1, 16'h004, 32'h12345678, 4'hF, 32'h0, 1, 2);
    apb("rd_gap", 0, 16'h008, 32'h0, 4'h0, 32'h0, 1, 2);
    apb("wr_sp_ro", 1, 16'h100, 32'h12345678, 4'hF, 32'h0, 1, 2);

    // Reset in the SP_WAIT cycle: outputs must drop without waiting for a clock.
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 16'h108;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    check("sp_wait_pready", {31'b0, pready}, 1);
    rst_ni = 1'b0;
    #1;
    check("arst_pready", {31'b0, pready}, 0);
    check("arst_prdata", prdata, 0);
    check("arst_pslverr", {31'b0, pslverr}, 0);
    check("arst_start", {31'b0, start}, 0);
    check("arst_sp_rd_en", {31'b0, sp_rd_en}, 0);
    check("arst_a_row0", a_rows[31:0], 0);
    psel = 1'b0; penable = 1'b0;
    repeat (2) @(posedge clk);
    check("scoreboard_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
